muldiv_ctrl: RTL

- Multi-cycle multiply/divide sequencer beside the execute-stage ALU.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the execute stage and owns the HI/LO architectural registers.
- Runs a fixed-latency multiply or a 32-iteration radix-2 restoring divide.
- Stalls the pipeline through busy_o until the result is committed; in-flight operations are killed on flush.

---
 rtl/muldiv_ctrl.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: multi-cycle multiply/divide sequencer that owns HI/LO.
// Multiply: product latched on accept, committed after MUL_LAT cycles in MUL.
// Divide: 32-step radix-2 restoring divide on magnitudes, sign fix-up in DIV_FIX.
module muldiv_ctrl #(
  parameter int MUL_LAT = 3
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        valid_i,
  input  logic [2:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        flush_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_MUL     = 2'd1,
    S_DIV     = 2'd2,
    S_DIV_FIX = 2'd3
  } state_t;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
  localparam logic [5:0] LP_MUL_LAT = 6'(MUL_LAT);
  localparam logic [5:0] LP_DIV_LAST = 6'd31;

  // two's-complement negate
  function automatic logic [31:0] f_neg(input logic [31:0] v);
    return (~v) + 32'd1;
  endfunction

  // magnitude of a signed 32-bit value (0x80000000 maps to itself, read as unsigned)
  function automatic logic [31:0] f_abs(input logic [31:0] v);
    logic [31:0] res;
    if (v[31]) begin
      res = f_neg(v);
    end else begin
      res = v;
    end
    return res;
  endfunction

  // architectural and sequencing state
  state_t      r_state;
  logic [5:0]  r_cnt;
  logic [63:0] r_prod;
  logic [31:0] r_quo;     // dividend shifts out of the top, quotient bits shift in
  logic [31:0] r_rem;
  logic [31:0] r_dvs;
  logic        r_qneg;
  logic        r_rneg;
  logic        r_dz;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic        r_done;

  // next-state values
  state_t      w_state_nxt;
  logic [5:0]  w_cnt_nxt;
  logic [63:0] w_prod_nxt;
  logic [31:0] w_quo_nxt;
  logic [31:0] w_rem_nxt;
  logic [31:0] w_dvs_nxt;
  logic        w_qneg_nxt;
  logic        w_rneg_nxt;
  logic        w_dz_nxt;
  logic [31:0] w_hi_nxt;
  logic [31:0] w_lo_nxt;
  logic        w_done_nxt;

  // qualifiers and datapath helpers
  logic        w_is_md;
  logic        w_req;
  logic        w_accept;
  logic        w_signed_div;
  logic [63:0] w_prod_s;
  logic [63:0] w_prod_u;
  logic [32:0] w_rem_sh;
  logic        w_fits;
  logic [31:0] w_diff;
  logic [31:0] w_fix_quo;
  logic [31:0] w_fix_rem;

  // a mul/div request that would start (or re-start) an operation; done_o masks the held op
  assign w_is_md   = ~op_i[2];
  assign w_req     = valid_i & w_is_md & ~r_done & ~flush_i;
  assign w_accept  = (r_state == S_IDLE) & w_req;
  assign busy_o    = resetn & ((r_state != S_IDLE) | w_req);

  assign w_signed_div = ~op_i[0];
  assign w_prod_s  = $signed({{32{a_i[31]}}, a_i}) * $signed({{32{b_i[31]}}, b_i});
  assign w_prod_u  = {32'd0, a_i} * {32'd0, b_i};

  // one restoring step: shift next dividend bit into the partial remainder, try subtract
  assign w_rem_sh  = {r_rem, r_quo[31]};
  assign w_fits    = (w_rem_sh >= {1'b0, r_dvs});
  assign w_diff    = w_rem_sh[31:0] - r_dvs;

  // sign fix-up; divide by zero forces an all-ones quotient, remainder already equals a_i
  assign w_fix_quo = r_dz ? 32'hFFFF_FFFF : (r_qneg ? f_neg(r_quo) : r_quo);
  assign w_fix_rem = r_rneg ? f_neg(r_rem) : r_rem;

  assign done_o = r_done;
  assign hi_o   = r_hi;
  assign lo_o   = r_lo;

  // next-state and datapath update; flush always returns to IDLE without committing
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_prod_nxt  = r_prod;
    w_quo_nxt   = r_quo;
    w_rem_nxt   = r_rem;
    w_dvs_nxt   = r_dvs;
    w_qneg_nxt  = r_qneg;
    w_rneg_nxt  = r_rneg;
    w_dz_nxt    = r_dz;
    w_hi_nxt    = r_hi;
    w_lo_nxt    = r_lo;
    w_done_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if ((op_i == OP_MULT) || (op_i == OP_MULTU)) begin
            w_prod_nxt  = op_i[0] ? w_prod_u : w_prod_s;
            w_cnt_nxt   = 6'd1;
            w_state_nxt = S_MUL;
          end else begin
            w_quo_nxt   = w_signed_div ? f_abs(a_i) : a_i;
            w_dvs_nxt   = w_signed_div ? f_abs(b_i) : b_i;
            w_rem_nxt   = 32'd0;
            w_qneg_nxt  = w_signed_div & (a_i[31] ^ b_i[31]);
            w_rneg_nxt  = w_signed_div & a_i[31];
            w_dz_nxt    = (b_i == 32'd0);
            w_cnt_nxt   = 6'd0;
            w_state_nxt = S_DIV;
          end
        end else if (valid_i && !flush_i && (op_i == OP_MTHI)) begin
          w_hi_nxt = a_i;
        end else if (valid_i && !flush_i && (op_i == OP_MTLO)) begin
          w_lo_nxt = a_i;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_MUL: begin
        if (flush_i) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = 6'd0;
        end else if (r_cnt == LP_MUL_LAT) begin
          w_hi_nxt    = r_prod[63:32];
          w_lo_nxt    = r_prod[31:0];
          w_done_nxt  = 1'b1;
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = 6'd0;
        end else begin
          w_cnt_nxt = r_cnt + 6'd1;
        end
      end
      S_DIV: begin
        if (flush_i) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = 6'd0;
        end else begin
          if (w_fits) begin
            w_rem_nxt = w_diff;
            w_quo_nxt = {r_quo[30:0], 1'b1};
          end else begin
            w_rem_nxt = w_rem_sh[31:0];
            w_quo_nxt = {r_quo[30:0], 1'b0};
          end
          if (r_cnt == LP_DIV_LAST) begin
            w_state_nxt = S_DIV_FIX;
            w_cnt_nxt   = 6'd0;
          end else begin
            w_cnt_nxt = r_cnt + 6'd1;
          end
        end
      end
      S_DIV_FIX: begin
        if (flush_i) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_lo_nxt    = w_fix_quo;
          w_hi_nxt    = w_fix_rem;
          w_done_nxt  = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = 6'd0;
      end
    endcase
  end

  // state register; asynchronous reset abandons any in-flight operation
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_cnt   <= 6'd0;
      r_prod  <= 64'd0;
      r_quo   <= 32'd0;
      r_rem   <= 32'd0;
      r_dvs   <= 32'd0;
      r_qneg  <= 1'b0;
      r_rneg  <= 1'b0;
      r_dz    <= 1'b0;
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_prod  <= w_prod_nxt;
      r_quo   <= w_quo_nxt;
      r_rem   <= w_rem_nxt;
      r_dvs   <= w_dvs_nxt;
      r_qneg  <= w_qneg_nxt;
      r_rneg  <= w_rneg_nxt;
      r_dz    <= w_dz_nxt;
      r_hi    <= w_hi_nxt;
      r_lo    <= w_lo_nxt;
      r_done  <= w_done_nxt;
    end
  end

endmodule
